// File: rtl/vector_div_iter.sv
// Iterative radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU results, one op in flight.
// Optional VECTOR_DIV_SPECIAL_FAST_EN: divide-by-zero and signed overflow skip the iteration.
module vector_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             in_signed_i,
   input  logic [WIDTH-1:0] in_a_i,
   input  logic [WIDTH-1:0] in_b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_quot_o,
   output logic [WIDTH-1:0] out_rem_o
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvs_q, quot_q, rem_q, a_q;
   logic [WIDTH-1:0] res_quot_q, res_rem_q;
   logic [CW-1:0]    cnt_q;
   logic             neg_quot_q, neg_rem_q, div0_q, ovf_q;

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // valid, once raised, holds its payload stable until that edge.
   logic             accept;
   logic             a_neg, b_neg, in_div0, in_ovf;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] rem_sub;
   logic             q_bit;
   logic [WIDTH-1:0] quot_fix, rem_fix;

   assign in_ready_o  = rst_ni && (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign out_quot_o  = out_valid_o ? res_quot_q : '0;
   assign out_rem_o   = out_valid_o ? res_rem_q : '0;

   assign accept  = in_valid_i && in_ready_o;
   assign a_neg   = in_signed_i && in_a_i[WIDTH-1];
   assign b_neg   = in_signed_i && in_b_i[WIDTH-1];
   // |MIN_INT| wraps to itself, which is exactly 2^(WIDTH-1) read as unsigned.
   assign a_abs   = a_neg ? -in_a_i : in_a_i;
   assign b_abs   = b_neg ? -in_b_i : in_b_i;
   assign in_div0 = (in_b_i == '0);
   assign in_ovf  = in_signed_i && (in_a_i == MIN_INT) && (in_b_i == '1);

   // The shifted partial remainder needs WIDTH+1 bits; after a subtraction it fits in WIDTH.
   assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
   assign q_bit     = (rem_shift >= {1'b0, dvs_q});
   assign rem_sub   = rem_shift[WIDTH-1:0] - dvs_q;

   assign quot_fix = div0_q ? '1 : (ovf_q ? MIN_INT : (neg_quot_q ? -quot_q : quot_q));
   assign rem_fix  = div0_q ? a_q : (ovf_q ? '0 : (neg_rem_q ? -rem_q : rem_q));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
`ifdef VECTOR_DIV_SPECIAL_FAST_EN
               if (in_div0 || in_ovf) state_d = DONE;
               else                   state_d = CALC;
`else
               state_d = CALC;
`endif
            end
         end
         CALC:    if (cnt_q == '0) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dvd_q      <= '0;
         dvs_q      <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         a_q        <= '0;
         res_quot_q <= '0;
         res_rem_q  <= '0;
         cnt_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         div0_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  dvd_q      <= a_abs;
                  dvs_q      <= b_abs;
                  a_q        <= in_a_i;
                  quot_q     <= '0;
                  rem_q      <= '0;
                  cnt_q      <= CW'(WIDTH - 1);
                  neg_quot_q <= a_neg ^ b_neg;
                  neg_rem_q  <= a_neg;
                  div0_q     <= in_div0;
                  ovf_q      <= in_ovf;
`ifdef VECTOR_DIV_SPECIAL_FAST_EN
                  res_quot_q <= in_div0 ? '1 : MIN_INT;
                  res_rem_q  <= in_div0 ? in_a_i : '0;
`endif
               end
            end
            CALC: begin
               rem_q  <= q_bit ? rem_sub : rem_shift[WIDTH-1:0];
               quot_q <= {quot_q[WIDTH-2:0], q_bit};
               dvd_q  <= dvd_q << 1;
               cnt_q  <= cnt_q - CW'(1);
            end
            FIX: begin
               res_quot_q <= quot_fix;
               res_rem_q  <= rem_fix;
            end
            default: ;
         endcase
      end
   end

endmodule
